// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller:
// controller states, per-cycle control bundle and the hazard compare.
package hazard_stall_ctrl_pkg;

   localparam int REG_W = 3;
   localparam int CNT_W = 16;

   localparam logic [15:0] NOP_INSTR = 16'b0000100000000000;

   typedef enum logic [1:0] {
      CTL_RUN   = 2'd0,
      CTL_DWAIT = 2'd1,
      CTL_IWAIT = 2'd2,
      CTL_HALT  = 2'd3
   } ctl_state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_valid;
      logic exmem_en;
      logic memwb_en;
   } pipe_ctl_t;

   localparam pipe_ctl_t PC_NORMAL = '{
      pc_write: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
      idex_en: 1'b1, idex_valid: 1'b1,
      exmem_en: 1'b1, memwb_en: 1'b1};

   localparam pipe_ctl_t PC_FREEZE = '{
      pc_write: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
      idex_en: 1'b0, idex_valid: 1'b1,
      exmem_en: 1'b0, memwb_en: 1'b0};

   localparam pipe_ctl_t PC_BRANCH = '{
      pc_write: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
      idex_en: 1'b1, idex_valid: 1'b0,
      exmem_en: 1'b1, memwb_en: 1'b1};

   // I-cache miss: NOPs enter decode while older work drains
   localparam pipe_ctl_t PC_IFILL = '{
      pc_write: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
      idex_en: 1'b1, idex_valid: 1'b1,
      exmem_en: 1'b1, memwb_en: 1'b1};

   localparam pipe_ctl_t PC_BUBBLE = '{
      pc_write: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
      idex_en: 1'b1, idex_valid: 1'b0,
      exmem_en: 1'b1, memwb_en: 1'b1};

   localparam pipe_ctl_t PC_HALTED = '{
      pc_write: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
      idex_en: 1'b1, idex_valid: 1'b0,
      exmem_en: 1'b1, memwb_en: 1'b1};

   localparam pipe_ctl_t PC_RESET = '{
      pc_write: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
      idex_en: 1'b1, idex_valid: 1'b0,
      exmem_en: 1'b1, memwb_en: 1'b1};

   function automatic logic load_use(
      input logic             mem_rd,
      input logic [REG_W-1:0] rd,
      input logic [REG_W-1:0] rs,
      input logic             rs_used,
      input logic [REG_W-1:0] rt,
      input logic             rt_used
   );
      return mem_rd & ((rs_used & (rs == rd)) |
                       (rt_used & (rt == rd)));
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs and stage-register controls between the
// pipeline datapath (master) and the stall controller (slave).
interface hazard_stall_ctrl_if;
   import hazard_stall_ctrl_pkg::*;

   logic [REG_W-1:0] IfId_Rs;
   logic [REG_W-1:0] IfId_Rt;
   logic             IfId_RsUsed;
   logic             IfId_RtUsed;
   logic             IdEx_MemRead;
   logic [REG_W-1:0] IdEx_Rd;
   logic             BrTaken_ex;
   logic             IMem_Stall;
   logic             IMem_Done;
   logic             DMem_Stall;
   logic             DMem_Done;
   logic             Halt_wb;

   logic             PCWrite;
   logic             IfIdEn;
   logic             IfIdFlush;
   logic             IdExEn;
   logic             IdExValid;
   logic             ExMemEn;
   logic             MemWbEn;
   logic             Halted;
   logic [CNT_W-1:0] LuStallCnt;
   logic [CNT_W-1:0] MemStallCnt;

   modport master (
      output IfId_Rs, IfId_Rt, IfId_RsUsed, IfId_RtUsed,
      output IdEx_MemRead, IdEx_Rd, BrTaken_ex,
      output IMem_Stall, IMem_Done, DMem_Stall, DMem_Done,
      output Halt_wb,
      input  PCWrite, IfIdEn, IfIdFlush, IdExEn, IdExValid,
      input  ExMemEn, MemWbEn, Halted,
      input  LuStallCnt, MemStallCnt
   );

   modport slave (
      input  IfId_Rs, IfId_Rt, IfId_RsUsed, IfId_RtUsed,
      input  IdEx_MemRead, IdEx_Rd, BrTaken_ex,
      input  IMem_Stall, IMem_Done, DMem_Stall, DMem_Done,
      input  Halt_wb,
      output PCWrite, IfIdEn, IfIdFlush, IdExEn, IdExValid,
      output ExMemEn, MemWbEn, Halted,
      output LuStallCnt, MemStallCnt
   );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module hazard_stall_ctrl_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch
// redirects, I/D cache freezes, halt latch and stall counters.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   hazard_stall_ctrl_if.slave bus
);

   ctl_state_e state_q;
   ctl_state_e state_d;
   logic       redir_q;
   logic       redir_d;
   logic       brh_q;
   logic       brh_d;

   pipe_ctl_t  ctl;
   logic       lu_hit;
   logic       lu_inc;
   logic       mem_inc;

   pipe_ctl_t  run_ctl;
   ctl_state_e run_state;
   logic       run_dstall;
   logic       run_br;
   logic       run_redir;
   logic       run_brh;
   logic       run_lu;
   logic       run_mem;

   assign lu_hit = load_use(bus.IdEx_MemRead, bus.IdEx_Rd,
                            bus.IfId_Rs, bus.IfId_RsUsed,
                            bus.IfId_Rt, bus.IfId_RtUsed);

   // A branch resolved while frozen is remembered in brh_q
   assign run_dstall = (state_q == CTL_RUN) & bus.DMem_Stall;
   assign run_br     = bus.BrTaken_ex | brh_q;

   always_comb begin
      run_ctl   = PC_NORMAL;
      run_state = CTL_RUN;
      run_redir = redir_q;
      run_brh   = 1'b0;
      run_lu    = 1'b0;
      run_mem   = 1'b0;
      if (run_dstall) begin
         run_ctl   = PC_FREEZE;
         run_state = CTL_DWAIT;
         run_brh   = bus.BrTaken_ex;
         run_mem   = 1'b1;
      end else if (run_br) begin
         run_ctl = PC_BRANCH;
         if (bus.IMem_Stall) begin
            run_redir = 1'b1;
            run_state = CTL_IWAIT;
            run_mem   = 1'b1;
         end
      end else if (bus.IMem_Stall) begin
         run_ctl   = PC_IFILL;
         run_state = CTL_IWAIT;
         run_mem   = 1'b1;
      end else if (lu_hit) begin
         run_ctl = PC_BUBBLE;
         run_lu  = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      redir_d = redir_q;
      brh_d   = brh_q;
      ctl     = PC_NORMAL;
      lu_inc  = 1'b0;
      mem_inc = 1'b0;
      if (bus.Halt_wb || (state_q == CTL_HALT)) begin
         ctl     = PC_HALTED;
         state_d = CTL_HALT;
      end else begin
         unique case (state_q)
            CTL_DWAIT: begin
               if (bus.DMem_Done) begin
                  ctl     = run_ctl;
                  state_d = run_state;
                  redir_d = run_redir;
                  brh_d   = 1'b0;
                  lu_inc  = run_lu;
                  mem_inc = run_mem;
               end else begin
                  ctl     = PC_FREEZE;
                  brh_d   = brh_q | bus.BrTaken_ex;
                  mem_inc = 1'b1;
               end
            end
            CTL_IWAIT: begin
               if (bus.DMem_Stall) begin
                  ctl     = PC_FREEZE;
                  state_d = CTL_DWAIT;
                  brh_d   = bus.BrTaken_ex;
                  mem_inc = 1'b1;
               end else if (bus.IMem_Done) begin
                  // Word fetched from a stale PC is dropped
                  ctl            = PC_NORMAL;
                  ctl.ifid_flush = redir_q | bus.BrTaken_ex;
                  ctl.idex_valid = ~bus.BrTaken_ex;
                  state_d        = CTL_RUN;
                  redir_d        = 1'b0;
               end else if (bus.BrTaken_ex) begin
                  ctl     = PC_BRANCH;
                  redir_d = 1'b1;
                  mem_inc = 1'b1;
               end else begin
                  ctl     = PC_IFILL;
                  mem_inc = 1'b1;
               end
            end
            default: begin
               ctl     = run_ctl;
               state_d = run_state;
               redir_d = run_redir;
               brh_d   = run_brh;
               lu_inc  = run_lu;
               mem_inc = run_mem;
            end
         endcase
      end
      if (rst) begin
         ctl     = PC_RESET;
         state_d = CTL_RUN;
         redir_d = 1'b0;
         brh_d   = 1'b0;
         lu_inc  = 1'b0;
         mem_inc = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CTL_RUN;
         redir_q <= 1'b0;
         brh_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         redir_q <= redir_d;
         brh_q   <= brh_d;
      end
   end

   hazard_stall_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_lu_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (lu_inc),
      .cnt_o (bus.LuStallCnt)
   );

   hazard_stall_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_mem_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (mem_inc),
      .cnt_o (bus.MemStallCnt)
   );

   assign bus.PCWrite   = ctl.pc_write;
   assign bus.IfIdEn    = ctl.ifid_en;
   assign bus.IfIdFlush = ctl.ifid_flush;
   assign bus.IdExEn    = ctl.idex_en;
   assign bus.IdExValid = ctl.idex_valid;
   assign bus.ExMemEn   = ctl.exmem_en;
   assign bus.MemWbEn   = ctl.memwb_en;
   assign bus.Halted    = (state_q == CTL_HALT) & ~rst;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected controls are
// queued per driven cycle and compared on the falling edge.
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;

   // {PCWrite,IfIdEn,IfIdFlush,IdExEn,IdExValid,ExMemEn,MemWbEn}
   localparam logic [6:0] NRM  = 7'b1101111;
   localparam logic [6:0] FRZ  = 7'b0000100;
   localparam logic [6:0] BR   = 7'b1111011;
   localparam logic [6:0] IFL  = 7'b0111111;
   localparam logic [6:0] BUB  = 7'b0001011;
   localparam logic [6:0] HLT  = 7'b0001011;
   localparam logic [6:0] RST  = 7'b0111011;
   localparam logic [6:0] DONR = 7'b1111111;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   int   lu_exp;
   int   mem_exp;

   string      q_tag[$];
   logic [6:0] q_ctl[$];
   logic       q_hlt[$];
   int         q_lu[$];
   int         q_mem[$];

   hazard_stall_ctrl_if bus ();

   hazard_stall_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      string      t;
      logic [6:0] ec;
      logic       eh;
      int         el;
      int         em;
      if (q_tag.size() != 0) begin
         t  = q_tag.pop_front();
         ec = q_ctl.pop_front();
         eh = q_hlt.pop_front();
         el = q_lu.pop_front();
         em = q_mem.pop_front();
         chk({t, ".ctl"}, 32'({bus.PCWrite, bus.IfIdEn, bus.IfIdFlush,
                               bus.IdExEn, bus.IdExValid, bus.ExMemEn,
                               bus.MemWbEn}), 32'(ec));
         chk({t, ".halted"}, 32'(bus.Halted), 32'(eh));
         chk({t, ".lucnt"}, 32'(bus.LuStallCnt), el);
         chk({t, ".memcnt"}, 32'(bus.MemStallCnt), em);
      end
   end

   task automatic idle();
      bus.IfId_Rs      = '0;
      bus.IfId_Rt      = '0;
      bus.IfId_RsUsed  = 1'b0;
      bus.IfId_RtUsed  = 1'b0;
      bus.IdEx_MemRead = 1'b0;
      bus.IdEx_Rd      = '0;
      bus.BrTaken_ex   = 1'b0;
      bus.IMem_Stall   = 1'b0;
      bus.IMem_Done    = 1'b0;
      bus.DMem_Stall   = 1'b0;
      bus.DMem_Done    = 1'b0;
      bus.Halt_wb      = 1'b0;
   endtask

   task automatic ld(input int rd, input int rs, input bit rsu,
                     input int rt, input bit rtu);
      bus.IdEx_MemRead = 1'b1;
      bus.IdEx_Rd      = REG_W'(rd);
      bus.IfId_Rs      = REG_W'(rs);
      bus.IfId_RsUsed  = rsu;
      bus.IfId_Rt      = REG_W'(rt);
      bus.IfId_RtUsed  = rtu;
   endtask

   // Inputs already driven; queue expectation and advance one cycle
   task automatic cyc(input string tag, input logic [6:0] ec,
                      input logic eh, input int dlu, input int dmem);
      q_tag.push_back(tag);
      q_ctl.push_back(ec);
      q_hlt.push_back(eh);
      q_lu.push_back(lu_exp);
      q_mem.push_back(mem_exp);
      @(posedge clk);
      #1;
      lu_exp  += dlu;
      mem_exp += dmem;
   endtask

   task automatic reset_cyc(input string tag, input logic eh);
      idle();
      rst = 1'b1;
      cyc(tag, RST, eh, 0, 0);
      rst = 1'b0;
      lu_exp  = 0;
      mem_exp = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      lu_exp  = 0;
      mem_exp = 0;
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      reset_cyc("reset", 1'b0);

      idle(); cyc("normal", NRM, 1'b0, 0, 0);

      idle(); ld(3, 3, 1, 2, 1); cyc("lu_rs", BUB, 1'b0, 1, 0);
      bus.IdEx_MemRead = 1'b0;   cyc("lu_once", NRM, 1'b0, 0, 0);

      idle(); ld(6, 5, 1, 6, 1); cyc("lu_rt", BUB, 1'b0, 1, 0);
      idle();                    cyc("lu_rt_nx", NRM, 1'b0, 0, 0);

      idle(); ld(3, 3, 0, 3, 0); cyc("lu_unused", NRM, 1'b0, 0, 0);
      idle(); ld(3, 3, 1, 3, 1);
      bus.IdEx_MemRead = 1'b0;   cyc("no_load", NRM, 1'b0, 0, 0);

      idle();
      bus.DMem_Stall = 1'b1;
      for (int i = 0; i < 4; i++) cyc("dstall", FRZ, 1'b0, 0, 1);
      bus.DMem_Stall = 1'b0;
      bus.DMem_Done  = 1'b1;     cyc("ddone", NRM, 1'b0, 0, 0);
      idle();                    cyc("d_after", NRM, 1'b0, 0, 0);

      idle();
      bus.DMem_Stall = 1'b1;     cyc("dbr_0", FRZ, 1'b0, 0, 1);
      bus.BrTaken_ex = 1'b1;     cyc("dbr_1", FRZ, 1'b0, 0, 1);
      idle();
      bus.DMem_Done  = 1'b1;     cyc("dbr_done", BR, 1'b0, 0, 0);
      idle();                    cyc("dbr_after", NRM, 1'b0, 0, 0);

      idle();
      bus.DMem_Stall = 1'b1;
      bus.BrTaken_ex = 1'b1;     cyc("d_over_br", FRZ, 1'b0, 0, 1);
      bus.DMem_Stall = 1'b0;
      bus.DMem_Done  = 1'b1;     cyc("d_br_done", BR, 1'b0, 0, 0);

      idle();
      bus.BrTaken_ex = 1'b1;
      bus.IMem_Stall = 1'b1;     cyc("br_istall", BR, 1'b0, 0, 1);
      bus.BrTaken_ex = 1'b0;
      for (int i = 0; i < 2; i++) cyc("iwait", IFL, 1'b0, 0, 1);
      bus.IMem_Stall = 1'b0;
      bus.IMem_Done  = 1'b1;     cyc("idone_redir", DONR, 1'b0, 0, 0);
      idle();
      bus.IMem_Stall = 1'b1;     cyc("istall", IFL, 1'b0, 0, 1);
      bus.IMem_Stall = 1'b0;
      bus.IMem_Done  = 1'b1;     cyc("idone_plain", NRM, 1'b0, 0, 0);

      idle(); ld(3, 3, 1, 0, 0);
      bus.BrTaken_ex = 1'b1;     cyc("br_over_lu", BR, 1'b0, 0, 0);
      idle(); ld(2, 1, 1, 2, 1);
      bus.IMem_Stall = 1'b1;     cyc("i_over_lu", IFL, 1'b0, 0, 1);
      idle();
      bus.IMem_Done  = 1'b1;     cyc("i_lu_done", NRM, 1'b0, 0, 0);

      idle();
      bus.Halt_wb = 1'b1;        cyc("halt_0", HLT, 1'b0, 0, 0);
      idle();
      bus.BrTaken_ex = 1'b1;     cyc("halt_1", HLT, 1'b1, 0, 0);
      idle();
      bus.DMem_Stall = 1'b1;     cyc("halt_2", HLT, 1'b1, 0, 0);
      idle(); ld(3, 3, 1, 0, 0); cyc("halt_3", HLT, 1'b1, 0, 0);
      reset_cyc("halt_rst", 1'b0);
      idle();                    cyc("post_halt", NRM, 1'b0, 0, 0);

      idle();
      bus.DMem_Stall = 1'b1;     cyc("mid_stall", FRZ, 1'b0, 0, 1);
      reset_cyc("stall_rst", 1'b0);
      idle();                    cyc("post_srst", NRM, 1'b0, 0, 0);
      idle();                    cyc("post_srst2", NRM, 1'b0, 0, 0);

      @(negedge clk);
      #1;
      chk("sb_drain", 32'(q_tag.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
